obstacle_feeder: RTL and testbench

//   Upstream stage of the player/collision logic. Holds the on-screen obstacles in a depth-ordered circular buffer.

---
 rtl/obstacle_feeder.sv | 133 +++++++++++++
 tb/tb_obstacle_feeder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_feeder.sv
// Depth-ordered circular buffer of on-screen obstacles: scrolls them toward the
// player each frame, retires the ones that passed, then streams the rest.
module obstacle_feeder #(
    parameter int SLOTS             = 16,
    parameter int SPEED             = 4,
    parameter int HALF_BLOCK_LENGTH = 64,
    parameter int FIRSTROW_DEPTH    = 2 * HALF_BLOCK_LENGTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     new_frame,
    input  logic                     game_over,
    input  logic [15:0]              gen_obstacle,
    input  logic                     gen_valid,
    output logic                     gen_ready,
    output logic [15:0]              obstacle,
    output logic                     obstacle_valid,
    output logic                     firstrow,
    output logic                     frame_done,
    output logic                     overrun,
    output logic [$clog2(SLOTS):0]   count
);

    localparam int PW = $clog2(SLOTS);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL       = CW'(SLOTS);
    localparam logic [10:0]   SPEED_D    = 11'(SPEED);
    localparam logic [10:0]   FIRSTROW_D = 11'(FIRSTROW_DEPTH);

    typedef enum logic [2:0] {IDLE, SCROLL, RETIRE, STREAM, DONE} state_t;

    state_t            state, next_state;
    logic [15:0]       entries [SLOTS];
    logic [SLOTS-1:0]  expired;
    logic [PW-1:0]     head, tail, rd_ptr;
    logic [CW-1:0]     idx;
    logic              push, pop, clear_idx, stream_last;
    logic [15:0]       stream_entry;

    assign push         = gen_valid && gen_ready;
    assign rd_ptr       = head + idx[PW-1:0];
    assign stream_entry = entries[rd_ptr];
    assign stream_last  = (idx + CW'(1)) == count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        gen_ready  = 1'b0;
        pop        = 1'b0;
        clear_idx  = 1'b0;
        case (state)
            IDLE: begin
                gen_ready = rst_n && (count < FULL);
                if (new_frame && !game_over) next_state = SCROLL;
            end
            SCROLL: next_state = RETIRE;
            RETIRE: begin
                if (count != '0 && expired[head]) begin
                    pop = 1'b1;
                end else begin
                    clear_idx  = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: if (count == '0 || stream_last) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            expired <= '0;
        end else begin
            if (push) begin
                tail          <= tail + 1'b1;
                expired[tail] <= 1'b0;
            end
            if (pop) begin
                head          <= head + 1'b1;
                expired[head] <= 1'b0;
            end
            if (state == SCROLL) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (entries[i][10:0] < SPEED_D) expired[i] <= 1'b1;
                end
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Dead slots are scrolled too; a push rewrites both the entry and its flag.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= gen_obstacle;
        if (state == SCROLL) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (entries[i][10:0] >= SPEED_D)
                    entries[i][10:0] <= entries[i][10:0] - SPEED_D;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obstacle       <= '0;
            obstacle_valid <= 1'b0;
            firstrow       <= 1'b0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
            idx            <= '0;
        end else begin
            obstacle_valid <= 1'b0;
            frame_done     <= 1'b0;
            if (new_frame && state != IDLE) overrun <= 1'b1;
            if (clear_idx) idx <= '0;
            if (state == STREAM && count != '0) begin
                obstacle       <= stream_entry;
                obstacle_valid <= 1'b1;
                firstrow       <= stream_entry[10:0] < FIRSTROW_D;
                idx            <= idx + 1'b1;
            end
            if (state == DONE) frame_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obstacle_feeder.sv
// Self-checking bench for obstacle_feeder: directed scenarios plus random traffic
// compared every cycle against a list-based frame model.
module tb_obstacle_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_frame = 1'b0;
    logic        game_over = 1'b0;
    logic        gen_valid = 1'b0;
    logic [15:0] gen_obstacle = '0;
    logic        gen_ready;
    logic [15:0] obstacle;
    logic        obstacle_valid;
    logic        firstrow;
    logic        frame_done;
    logic        overrun;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;

    obstacle_feeder dut (
        .clk(clk), .rst_n(rst_n), .new_frame(new_frame), .game_over(game_over),
        .gen_obstacle(gen_obstacle), .gen_valid(gen_valid), .gen_ready(gen_ready),
        .obstacle(obstacle), .obstacle_valid(obstacle_valid), .firstrow(firstrow),
        .frame_done(frame_done), .overrun(overrun), .count(count)
    );

    always #5 clk = ~clk;

    // Model: the buffer is a plain list; a frame is a filter-and-subtract over it,
    // and its outputs are laid out on an absolute cycle timeline.
    int          cyc = 0;
    logic [15:0] q[$];
    logic [15:0] exp_stream [int];
    int          busy_lo = 1, busy_hi = 0, pops_end = 0, fstart = 0, cnt_pre = 0, done_cyc = -1;
    bit          ovr = 1'b0;
    logic [15:0] hold_obs = '0;
    bit          hold_fr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] mk(int ty, int lane, int depth);
        logic [2:0]  t3 = 3'(ty);
        logic [1:0]  l2 = 2'(lane);
        logic [10:0] d11 = 11'(depth);
        return {t3, l2, d11};
    endfunction

    function automatic void start_frame(int t);
        logic [15:0] kept[$];
        int p = 0;
        int m;
        foreach (q[i]) begin
            if (q[i][10:0] < 11'd4) p++;
            else kept.push_back({q[i][15:11], q[i][10:0] - 11'd4});
        end
        m        = (kept.size() > 0) ? kept.size() : 1;
        cnt_pre  = q.size();
        q        = kept;
        fstart   = t;
        busy_lo  = t + 1;
        busy_hi  = t + 3 + p + m;
        pops_end = t + 2 + p;
        done_cyc = busy_hi + 1;
        foreach (kept[k]) exp_stream[t + 4 + p + k] = kept[k];
    endfunction

    function automatic int exp_count(int c);
        if (c >= busy_lo && c < pops_end)
            return cnt_pre - (((c - fstart - 2) > 0) ? (c - fstart - 2) : 0);
        return q.size();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_stream.delete();
            busy_lo  = 1;
            busy_hi  = 0;
            pops_end = 0;
            done_cyc = -1;
            ovr      = 1'b0;
        end else if (cyc >= busy_lo && cyc <= busy_hi) begin
            if (new_frame) ovr = 1'b1;
        end else begin
            if (gen_valid && q.size() < 16) q.push_back(gen_obstacle);
            if (new_frame && !game_over) start_frame(cyc);
        end
    end

    always @(negedge clk) begin
        int ec;
        bit ev;
        bit busy;
        if (!rst_n) begin
            check("rst_valid", obstacle_valid, 0);
            check("rst_obstacle", obstacle, 0);
            check("rst_firstrow", firstrow, 0);
            check("rst_done", frame_done, 0);
            check("rst_overrun", overrun, 0);
            check("rst_count", count, 0);
            check("rst_ready", gen_ready, 0);
            hold_obs = '0;
            hold_fr  = 1'b0;
        end else begin
            ec   = exp_count(cyc);
            busy = (cyc >= busy_lo && cyc <= busy_hi);
            ev   = exp_stream.exists(cyc);
            if (ev) begin
                hold_obs = exp_stream[cyc];
                hold_fr  = hold_obs[10:0] < 11'd128;
            end
            check("valid", obstacle_valid, int'(ev));
            check("obstacle", obstacle, hold_obs);
            check("firstrow", firstrow, int'(hold_fr));
            check("frame_done", frame_done, int'(cyc == done_cyc));
            check("overrun", overrun, int'(ovr));
            check("count", count, ec);
            check("gen_ready", gen_ready, int'(!busy && ec < 16));
        end
    end

    task automatic apply_stimulus(input bit nf, input bit gv, input bit go, input logic [15:0] obs);
        @(negedge clk);
        #1;
        new_frame    = nf;
        gen_valid    = gv;
        game_over    = go;
        gen_obstacle = obs;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (n) apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        new_frame = 1'b0; gen_valid = 1'b0; game_over = 1'b0; gen_obstacle = '0;
    endtask

    initial begin
        int t;
        int base;
        int d;

        // Reset held with random inputs, then released
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            check("t1_ready_in_reset", gen_ready, 0);
            check("t1_count_in_reset", count, 0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        new_frame = 1'b0; gen_valid = 1'b0; game_over = 1'b0; gen_obstacle = '0;
        #1 check("t1_ready_after", gen_ready, 1);

        // Two entries straddling the first-row boundary
        apply_stimulus(0, 1, 0, mk(1, 0, 10));
        apply_stimulus(0, 1, 0, mk(2, 1, 300));
        apply_stimulus(1, 0, 0, '0);
        t = cyc;
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(0, 0, 0, '0);
            if (k == 3) check("t2_no_valid_t3", obstacle_valid, 0);
            if (k == 4) begin
                check("t2_valid_t4", obstacle_valid, 1);
                check("t2_obs_t4", obstacle, mk(1, 0, 6));
                check("t2_fr_t4", firstrow, 1);
                check("t2_count", count, 2);
            end
            if (k == 5) begin
                check("t2_obs_t5", obstacle, mk(2, 1, 296));
                check("t2_fr_t5", firstrow, 0);
            end
            if (k == 6) begin
                check("t2_done_t6", frame_done, 1);
                check("t2_valid_t6", obstacle_valid, 0);
            end
        end

        // Single entry that expires during the frame
        do_reset(2);
        apply_stimulus(0, 1, 0, mk(0, 2, 3));
        apply_stimulus(1, 0, 0, '0);
        t = cyc;
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(0, 0, 0, '0);
            check("t3_no_valid", obstacle_valid, 0);
            if (k == 4) check("t3_count", count, 0);
            if (k == 6) check("t3_done", frame_done, 1);
        end

        // Fill the buffer, stall the generator, pop one on the next frame
        do_reset(2);
        for (int i = 0; i < 16; i++) apply_stimulus(0, 1, 0, mk(i % 8, i % 4, 2 + 10 * i));
        apply_stimulus(0, 1, 0, mk(0, 0, 500));
        check("t4_full_count", count, 16);
        check("t4_full_ready", gen_ready, 0);
        apply_stimulus(1, 0, 0, '0);
        t = cyc;
        for (int k = 1; k <= 21; k++) begin
            apply_stimulus(0, 0, 0, '0);
            if (k == 5) check("t4_first_obs", obstacle, mk(1, 1, 8));
        end
        check("t4_count_after", count, 15);
        check("t4_ready_after", gen_ready, 1);

        // new_frame mid-stream is an overrun; game_over freezes the next frame
        apply_stimulus(1, 0, 0, '0);
        t = cyc;
        for (int k = 1; k <= 20; k++) begin
            apply_stimulus(k == 6, 0, 0, '0);
            if (k == 19) check("t5_done", frame_done, 1);
        end
        check("t5_overrun", overrun, 1);
        apply_stimulus(1, 0, 1, '0);
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(0, 0, 1, '0);
            check("t5_frozen_valid", obstacle_valid, 0);
            check("t5_frozen_count", count, 15);
        end
        apply_stimulus(0, 0, 0, '0);

        // Reset in the middle of a stream, then stream across a tail wrap
        apply_stimulus(1, 0, 0, '0);
        for (int k = 1; k <= 6; k++) apply_stimulus(0, 0, 0, '0);
        check("t6_valid_before_rst", obstacle_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("t6_valid_async_drop", obstacle_valid, 0);
        apply_stimulus(1, 1, 0, 16'($urandom));
        apply_stimulus(0, 1, 1, 16'($urandom));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        new_frame = 1'b0; gen_valid = 1'b0; game_over = 1'b0; gen_obstacle = '0;
        check("t6_count_after_rst", count, 0);
        for (int i = 0; i < 14; i++) apply_stimulus(0, 1, 0, mk(0, 0, 1));
        apply_stimulus(1, 0, 0, '0);
        for (int k = 1; k <= 20; k++) apply_stimulus(0, 0, 0, '0);
        check("t6_drained", count, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, mk(i, i % 4, 100 + 10 * i));
        apply_stimulus(0, 0, 0, '0);
        check("t6_count_wrap", count, 5);
        apply_stimulus(1, 0, 0, '0);
        for (int k = 1; k <= 10; k++) begin
            apply_stimulus(0, 0, 0, '0);
            if (k == 4) check("t6_wrap_first", obstacle, mk(0, 0, 96));
            if (k == 8) check("t6_wrap_last", obstacle, mk(4, 0, 136));
        end

        // Random traffic; pushes stay nondecreasing relative to the buffer tail
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset(2);
            @(negedge clk);
            #1;
            base = (q.size() > 0) ? int'(q[$][10:0]) : 0;
            d    = base + int'($urandom_range(0, 8));
            if (d > 2047) d = 2047;
            gen_valid    = ($urandom_range(0, 3) == 0);
            new_frame    = ($urandom_range(0, 3) == 0);
            game_over    = ($urandom_range(0, 11) == 0);
            gen_obstacle = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), d);
        end
        repeat (40) apply_stimulus(0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
